// File: rtl/qpsk_bit_packer_if.sv
// Handshake bundle for qpsk_bit_packer: serial bit stream in, packed word out.
interface qpsk_bit_packer_if #(
    parameter int unsigned WORD_W = 21,
    parameter int unsigned CNT_W  = 16
);
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output bit_in, bit_valid, flush, word_ready,
        input  bit_ready, word_out, word_valid, word_count
    );

    modport slave (
        input  bit_in, bit_valid, flush, word_ready,
        output bit_ready, word_out, word_valid, word_count
    );
endinterface

// File: rtl/qpsk_bit_packer.sv
// Packs a serial bit stream into WORD_W-bit words for the QPSK modulator, with one parked word.
// Define QPSK_PACKER_PARITY_EN to reserve word_out[0] for even parity over the data bits.
module qpsk_bit_packer #(
    parameter int unsigned WORD_W    = 21,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    qpsk_bit_packer_if.slave bus
);
`ifdef QPSK_PACKER_PARITY_EN
    localparam int unsigned DATA_W = WORD_W - 1;
`else
    localparam int unsigned DATA_W = WORD_W;
`endif
    localparam int unsigned FILL_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [FILL_W-1:0] fill;
    logic              parked;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic [CNT_W-1:0]  count_q;

    logic              accept_c;
    logic              handshake_c;
    logic              out_free_c;
    logic              complete_c;
    logic [FILL_W-1:0] pos_c;
    logic [FILL_W-1:0] fill_c;
    logic [DATA_W-1:0] data_c;

    function automatic logic [WORD_W-1:0] pack(input logic [DATA_W-1:0] d);
`ifdef QPSK_PACKER_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    assign bus.bit_ready  = !reset && !parked;
    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_count = count_q;

    // Shift register image including this cycle's bit, and word-completion decision.
    always_comb begin
        data_c      = shreg;
        fill_c      = fill;
        accept_c    = bus.bit_valid && bus.bit_ready;
        pos_c       = MSB_FIRST ? (FILL_W'(DATA_W - 1) - fill) : fill;
        if (accept_c) begin
            data_c[pos_c] = bus.bit_in;
            fill_c        = fill + FILL_W'(1);
        end
        handshake_c = word_valid_q && bus.word_ready;
        out_free_c  = !word_valid_q || bus.word_ready;
        complete_c  = !parked &&
                      ((accept_c && (fill_c == FILL_W'(DATA_W))) ||
                       (bus.flush && (fill_c != '0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg        <= '0;
            fill         <= '0;
            parked       <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            if (handshake_c) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (parked) begin
                // Parked word replaces the accepted one; word_valid stays high.
                if (bus.word_ready) begin
                    word_q <= pack(shreg);
                    parked <= 1'b0;
                    fill   <= '0;
                    shreg  <= '0;
                end
            end else if (complete_c && out_free_c) begin
                word_q       <= pack(data_c);
                word_valid_q <= 1'b1;
                fill         <= '0;
                shreg        <= '0;
            end else if (complete_c) begin
                parked <= 1'b1;
                shreg  <= data_c;
                fill   <= fill_c;
            end else begin
                shreg <= data_c;
                fill  <= fill_c;
                if (handshake_c) begin
                    word_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_qpsk_bit_packer.sv
// Self-checking bench for qpsk_bit_packer: directed scenarios plus a randomized run scored by a bit-queue model.
module tb_qpsk_bit_packer;
    localparam int unsigned WORD_W    = 21;
    localparam int unsigned CNT_W     = 16;
    localparam bit          MSB_FIRST = 1'b1;
`ifdef QPSK_PACKER_PARITY_EN
    localparam int unsigned DATA_W = WORD_W - 1;
`else
    localparam int unsigned DATA_W = WORD_W;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic              model_q[$];
    logic [WORD_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_cnt   = '0;
    logic              prev_hold = 1'b0;
    logic [WORD_W-1:0] prev_word = '0;

    qpsk_bit_packer_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    qpsk_bit_packer #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(MSB_FIRST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Word value implied by a list of received bits: ordering rule, zero padding, optional parity.
    function automatic logic [WORD_W-1:0] build_word(input logic q[$]);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (MSB_FIRST) w[WORD_W - 1 - i] = q[i];
            else           w[WORD_W - DATA_W + i] = q[i];
        end
`ifdef QPSK_PACKER_PARITY_EN
        w[0] = ^w[WORD_W-1:1];
`endif
        return w;
    endfunction

    // Scoreboard: bits and flushes observed on the input handshake form expected words in order.
    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            exp_q.delete();
            exp_cnt   = '0;
            prev_hold = 1'b0;
        end else begin
            checks++;
            if (bus.word_count !== exp_cnt) begin
                errors++;
                $display("FAIL word_count: got %0d want %0d at %0t", bus.word_count, exp_cnt, $time);
            end
            if (prev_hold) begin
                checks++;
                if (bus.word_valid !== 1'b1 || bus.word_out !== prev_word) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b word=%h want valid=1 word=%h at %0t",
                             bus.word_valid, bus.word_out, prev_word, $time);
                end
            end
            if (bus.bit_valid && bus.bit_ready) begin
                model_q.push_back(bus.bit_in);
                if (model_q.size() == DATA_W) begin
                    exp_q.push_back(build_word(model_q));
                    model_q.delete();
                end
            end
            if (bus.flush && bus.bit_ready && model_q.size() > 0) begin
                exp_q.push_back(build_word(model_q));
                model_q.delete();
            end
            if (bus.word_valid && bus.word_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_data: got %h want no word at %0t", bus.word_out, $time);
                end else begin
                    logic [WORD_W-1:0] w;
                    w = exp_q.pop_front();
                    if (bus.word_out !== w) begin
                        errors++;
                        $display("FAIL word_data: got %h want %h at %0t", bus.word_out, w, $time);
                    end
                end
                exp_cnt = exp_cnt + CNT_W'(1);
            end
            prev_hold = bus.word_valid && !bus.word_ready;
            prev_word = bus.word_out;
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.bit_valid = 1'b0;
        bus.flush     = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset          = 1'b1;
        bus.word_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.bit_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_low: got %b want 0", bus.bit_ready);
            end
            @(posedge clk);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bit_ready !== 1'b1 || bus.word_valid !== 1'b0 ||
            bus.word_out !== '0 || bus.word_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b word=%h count=%0d want 1 0 0 0",
                     bus.bit_ready, bus.word_valid, bus.word_out, bus.word_count);
        end
    endtask

    task automatic test_full_word();
        logic [WORD_W-1:0] val;
        logic [WORD_W-1:0] expw;
        int n;
`ifdef QPSK_PACKER_PARITY_EN
        val = 21'h0ABCDE; expw = 21'h1579BD; n = 20;
`else
        val = 21'h1ABCDE; expw = 21'h1ABCDE; n = 21;
`endif
        bus.word_ready = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            bus.bit_valid = 1'b1;
            bus.bit_in    = val[i];
            @(negedge clk);
            checks++;
            if (bus.bit_ready !== 1'b1 || bus.word_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_word_stream: bit %0d got ready=%b valid=%b want 1 0",
                         i, bus.bit_ready, bus.word_valid);
            end
        end
        @(posedge clk); #1 bus.bit_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== expw) begin
            errors++;
            $display("FAIL full_word_out: got valid=%b word=%h want 1 %h", bus.word_valid, bus.word_out, expw);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.word_count !== CNT_W'(1) || bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_word_count: got count=%0d valid=%b want 1 0", bus.word_count, bus.word_valid);
        end
    endtask

    task automatic test_flush();
        logic [4:0]        pat;
        logic [WORD_W-1:0] expf;
        pat = 5'b10110;
`ifdef QPSK_PACKER_PARITY_EN
        expf = 21'h160001;
`else
        expf = 21'h160000;
`endif
        bus.word_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            @(posedge clk); #1;
            bus.bit_valid = 1'b1;
            bus.bit_in    = pat[i];
        end
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_early: got valid=%b want 0", bus.word_valid);
        end
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== expf) begin
            errors++;
            $display("FAIL flush_word: got valid=%b word=%h want 1 %h", bus.word_valid, bus.word_out, expf);
        end
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.word_valid !== 1'b0 || bus.word_count !== CNT_W'(2)) begin
                errors++;
                $display("FAIL flush_empty: got valid=%b count=%0d want 0 2", bus.word_valid, bus.word_count);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        localparam int RAISE = 60;
        localparam int NBITS = 50;
        logic bits[NBITS];
        int acc = 0, ca = -1, cz = -1, cr = -1, acc_raise = -1;
        for (int i = 0; i < NBITS; i++) bits[i] = 1'($urandom);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            bus.word_ready = (cyc >= RAISE);
            bus.bit_valid  = (acc < NBITS);
            bus.bit_in     = bits[(acc < NBITS) ? acc : 0];
            @(negedge clk);
            if (bus.bit_valid && bus.bit_ready) begin
                acc++;
                if (acc == 2 * DATA_W) ca = cyc;
            end
            if (cz < 0 && !bus.bit_ready) cz = cyc;
            if (cyc == RAISE - 1) acc_raise = acc;
            if (cyc >= RAISE && cr < 0 && bus.bit_ready) cr = cyc;
            if (acc == NBITS && cyc > RAISE + 1) break;
        end
        checks++;
        if (acc_raise != 2 * DATA_W || cz != ca + 1) begin
            errors++;
            $display("FAIL bp_stall: got accepted=%0d drop_cycle=%0d want %0d %0d",
                     acc_raise, cz, 2 * DATA_W, ca + 1);
        end
        checks++;
        if (cr != RAISE + 1 || acc != NBITS) begin
            errors++;
            $display("FAIL bp_recover: got ready_cycle=%0d accepted=%0d want %0d %0d", cr, acc, RAISE + 1, NBITS);
        end
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        bus.flush     = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || model_q.size() != 0 || bus.word_valid !== 1'b0 || bus.word_count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL bp_drain: got pending=%0d valid=%b count=%0d want 0 0 5",
                     exp_q.size(), bus.word_valid, bus.word_count);
        end
    endtask

    task automatic test_reset_mid();
        logic              q[$];
        logic [WORD_W-1:0] expw;
        int acc;
        for (int pass = 0; pass < 2; pass++) begin
            acc = 0;
            bus.word_ready = 1'b0;
            for (int cyc = 0; cyc < 100 && acc < ((pass == 0) ? 2 * DATA_W : 7); cyc++) begin
                @(posedge clk); #1;
                bus.bit_valid = 1'b1;
                bus.bit_in    = 1'b1;
                @(negedge clk);
                if (bus.bit_ready) acc++;
            end
            do_reset(2);
            @(negedge clk);
            checks++;
            if (bus.word_valid !== 1'b0 || bus.word_out !== '0 ||
                bus.word_count !== '0 || bus.bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_%0d: got valid=%b word=%h count=%0d ready=%b want 0 0 0 1",
                         pass, bus.word_valid, bus.word_out, bus.word_count, bus.bit_ready);
            end
        end
        bus.word_ready = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            @(posedge clk); #1;
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'($urandom);
            q.push_back(bus.bit_in);
        end
        expw = build_word(q);
        @(posedge clk); #1 bus.bit_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== expw) begin
            errors++;
            $display("FAIL reset_clean_word: got valid=%b word=%h want 1 %h", bus.word_valid, bus.word_out, expw);
        end
    endtask

    task automatic test_random();
        int waited = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            bus.bit_valid  = ($urandom % 4) != 0;
            bus.bit_in     = 1'($urandom);
            bus.flush      = ($urandom % 16) == 0;
            bus.word_ready = ((cyc / 300) % 2 == 0) ? (($urandom % 3) != 0) : (($urandom % 5) == 0);
        end
        @(posedge clk); #1;
        bus.bit_valid  = 1'b0;
        bus.word_ready = 1'b1;
        bus.flush      = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        while (waited < 50 && (bus.word_valid || exp_q.size() != 0)) begin
            @(posedge clk); #1;
            waited++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || model_q.size() != 0 || bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got pending=%0d partial=%0d valid=%b want 0 0 0",
                     exp_q.size(), model_q.size(), bus.word_valid);
        end
    endtask

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/qpsk_bit_packer.md
# qpsk_bit_packer

Upstream feeder for the QPSK modulator. Accepts a serial bit stream over a valid/ready handshake, packs bits into 21-bit words and presents each completed word on a registered valid/ready output that drives the modulator's 21-bit data input. A one-word parking buffer lets packing continue while the output word waits for acceptance. A flush input closes a partial word with zero padding.

## Interface
- `WORD_W`, 21, output word width; matches modulator input width.
- `MSB_FIRST`, 1, 1 = first received bit lands in the highest data bit; 0 = lowest data bit.
- `CNT_W`, 16, width of the completed-word counter.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `bit_in` in 1: serial data bit.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: packer can accept a bit this cycle.
- `flush` in 1: single-cycle request to close a partial word.
- `word_out` out WORD_W: packed word; feeds modulator data input.
- `word_valid` out 1: `word_out` holds an unaccepted word.
- `word_ready` in 1: consumer accepts `word_out` this cycle.
- `word_count` out CNT_W: number of words accepted downstream; wraps modulo 2^CNT_W.

## Operation
- DATA_W = WORD_W (no parity) or WORD_W−1 (parity build). Data bits sit in `word_out[WORD_W-1 : WORD_W-DATA_W]`.
- State:
  - shift register of DATA_W bits;
  - `fill` count 0..DATA_W;
  - `parked` flag (shift register holds a complete word);
  - output register plus `word_valid`.
- Bit acceptance:
  - Bit accepted when `bit_valid && bit_ready`.
  - `bit_ready = !reset && !parked`.
  - Accepted bit is written to the position given by `fill` and `MSB_FIRST`; `fill` increments.
- Word completion happens when the accepted bit makes `fill` reach DATA_W, or when a flush is taken with `fill` > 0 (after including any bit accepted in the same cycle). Unfilled positions are zero. At completion:
  - If the output is free this cycle (`!word_valid || word_ready`): the word loads into the output register, `word_valid` = 1 next cycle, `fill` → 0.
  - Otherwise: `parked` = 1, `fill` holds.
- Parked word moves to the output on the first cycle where `word_ready` = 1. At that edge: `parked` → 0, `fill` → 0, `word_valid` stays 1 with the new word.
- Output handshake: `word_valid && word_ready` → `word_count` increments. `word_valid` falls next cycle unless a new word loads on the same edge.
- `word_out` and `word_valid` stay stable while `word_valid && !word_ready`.
- Flush rules:
  - Ignored when `fill` == 0 and no bit is accepted that cycle.
  - Ignored while `parked`.
  - A flush coinciding with the DATA_W-th bit is redundant and produces one word.
- Reset mid-word discards the partial word, any parked word and the output word. No partial output is emitted.

## Timing
- Reset values:
  - `word_out` = 0, `word_valid` = 0, `word_count` = 0.
  - `fill` = 0, `parked` = 0.
  - `bit_ready` = 0 while `reset` is high, 1 on the first cycle after.
- Latency: completing bit or flush accepted in cycle N → `word_valid` = 1 in cycle N+1, provided the output is free in cycle N.
- Throughput: with `word_ready` held at 1, one word per DATA_W accepted bits, with no bubbles on `bit_ready`.
- Backpressure:
  - At most two words are buffered: one in the output register, one parked.
  - `bit_ready` drops the cycle after parking.
  - `bit_ready` returns the cycle after the parked word transfers to the output.
- `word_count` updates in the cycle after the handshake.

## Configuration
- `QPSK_PACKER_PARITY_EN`:
  - Defined: DATA_W = WORD_W−1, and `word_out[0]` is the even-parity bit over the DATA_W data bits (XOR of the data bits). Parity is computed at completion, including zero padding.
  - Undefined: DATA_W = WORD_W, and all bits are data.

## Test plan
- Reset/idle: hold `reset` for 3 cycles, then release → `bit_ready` = 0 during reset and 1 after; `word_valid` = 0, `word_out` = 0, `word_count` = 0.
- Full word, no parity, MSB_FIRST=1, `word_ready` = 1: stream the bits of 0x1ABCDE MSB first on back-to-back cycles → `word_out` = 0x1ABCDE with `word_valid` = 1 exactly one cycle after the 21st bit; `word_count` = 1.
- Parity build: stream 20 bits of 0xABCDE MSB first → `word_out` = 0x1579BD (parity bit 1).
- Flush: bits 1,0,1,1,0, then a `flush` pulse → `word_out` = 0x160000, `word_valid` next cycle. A second `flush` with `fill` = 0 → no word.
- Backpressure: `word_ready` = 0, stream 50 bits → first word valid and stable; second word parks after bit 42; `bit_ready` = 0 from the next cycle; bits 43+ stall. Raise `word_ready` → both words delivered in order, `bit_ready` recovers, and no bit is lost or duplicated.
- Reset mid-operation: assert `reset` with a parked word and `fill` = 7 → all state cleared; the next 21 bits form a clean word.
